// File: rtl/ctrl_step_sequencer.sv
// rtl/ctrl_step_sequencer.sv - one-hot control step sequencer with memory wait states, halt and bus-timeout fault
module ctrl_step_sequencer #(
    parameter int                   NUM_STEPS     = 5,
    parameter logic [NUM_STEPS-1:0] MEM_STEP_MASK = 5'b01001,
    parameter int                   WAIT_LIMIT    = 15
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iRdy,
    input  logic                         iMemNeed,
    input  logic                         iLastStep,
    input  logic                         iHalt,
    input  logic                         iResume,
    input  logic                         iMemAck,
    output logic                         oMemReq,
    output logic [NUM_STEPS-1:0]         oStep,
    output logic [$clog2(NUM_STEPS)-1:0] oStepIdx,
    output logic                         oIR_en,
    output logic                         oInstrDone,
    output logic                         oHalted,
    output logic                         oFault
);

    localparam int                 IDX_W    = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_STEPS - 1);
    localparam logic [7:0]         LIMIT    = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_MEM,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_STEPS-1:0]   step_q, step_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic mem_step;
    logic end_step;
    logic advance;
    logic complete;

    // Step 0 is the instruction fetch, so it always waits for memory.
    assign mem_step = (idx_q == '0) || (MEM_STEP_MASK[idx_q] && iMemNeed);
    assign end_step = iLastStep || (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (iRdy) begin
                    if (mem_step) begin
                        state_d = ST_WAIT_MEM;
                        cnt_d   = '0;
                    end else if (end_step) begin
                        complete = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // An ack in the limit cycle still completes the access.
                if (iMemAck) begin
                    state_d = ST_RUN;
                    if (end_step) begin
                        complete = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LIMIT) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_HALT: begin
                if (iResume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase

        if (advance) begin
            step_d = {step_q[NUM_STEPS-2:0], step_q[NUM_STEPS-1]};
            idx_d  = idx_q + IDX_W'(1);
        end

        if (complete) begin
            step_d  = NUM_STEPS'(1);
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = iHalt ? ST_HALT : ST_RUN;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_RUN;
            step_q  <= NUM_STEPS'(1);
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign oMemReq    = (state_q == ST_WAIT_MEM);
    assign oHalted    = (state_q == ST_HALT);
    assign oFault     = (state_q == ST_FAULT);
    assign oStep      = step_q;
    assign oStepIdx   = idx_q;
    assign oInstrDone = done_q;
    assign oIR_en     = (state_q == ST_WAIT_MEM) && (idx_q == '0) && iMemAck;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// tb/tb_ctrl_step_sequencer.sv - self-checking bench for ctrl_step_sequencer
module tb_ctrl_step_sequencer;

    localparam int         N     = 5;
    localparam int         LIMIT = 15;
    localparam logic [4:0] MASK  = 5'b01001;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst, rdy, need, last, halt, resume, ack;
    logic       mem_req, ir_en, instr_done, halted, fault;
    logic [4:0] step;
    logic [2:0] step_idx;

    ctrl_step_sequencer #(
        .NUM_STEPS     (N),
        .MEM_STEP_MASK (MASK),
        .WAIT_LIMIT    (LIMIT)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iRdy       (rdy),
        .iMemNeed   (need),
        .iLastStep  (last),
        .iHalt      (halt),
        .iResume    (resume),
        .iMemAck    (ack),
        .oMemReq    (mem_req),
        .oStep      (step),
        .oStepIdx   (step_idx),
        .oIR_en     (ir_en),
        .oInstrDone (instr_done),
        .oHalted    (halted),
        .oFault     (fault)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_mode = M_RUN;
    int   m_idx = 0;
    int   m_cnt = 0;
    bit   m_done = 1'b0;
    bit   m_valid = 1'b0;
    logic last_iren;

    typedef struct {
        logic       rst, rdy, need, last, halt, resume, ack;
        logic [4:0] step;
        logic       req, iren, done, hlt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic rd, input logic nd, input logic ls,
                          input logic hl, input logic rs, input logic ak);
        rst = r; rdy = rd; need = nd; last = ls; halt = hl; resume = rs; ack = ak;
    endtask

    // Reference: an instruction is a walk over step indices; memory steps cost one extra
    // cycle per un-acked wait, completion returns to index 0.
    task automatic model_edge();
        bit end_c;
        bit finish;
        finish = 1'b0;
        if (rst) begin
            m_mode = M_RUN; m_idx = 0; m_cnt = 0; m_done = 1'b0; m_valid = 1'b1;
            return;
        end
        m_done = 1'b0;
        end_c  = last || (m_idx == N - 1);
        case (m_mode)
            M_RUN: if (rdy) begin
                if (m_idx == 0 || (MASK[m_idx] && need)) begin
                    m_mode = M_WAIT; m_cnt = 0;
                end else if (end_c) finish = 1'b1;
                else m_idx++;
            end
            M_WAIT: if (ack) begin
                m_mode = M_RUN;
                if (end_c) finish = 1'b1;
                else m_idx++;
            end else begin
                m_cnt++;
                if (m_cnt >= LIMIT) m_mode = M_FAULT;
            end
            M_HALT: if (resume) m_mode = M_RUN;
            default: ;
        endcase
        if (finish) begin
            m_idx = 0; m_done = 1'b1;
            m_mode = halt ? M_HALT : M_RUN;
        end
    endtask

    task automatic tick();
        #1;
        last_iren = ir_en;
        if (m_valid) chk("ir_en", ir_en, (m_mode == M_WAIT && m_idx == 0 && ack));
        @(posedge clk);
        model_edge();
        #1;
        chk("step", step, 1 << m_idx);
        chk("step_idx", step_idx, m_idx);
        chk("mem_req", mem_req, m_mode == M_WAIT);
        chk("instr_done", instr_done, m_done);
        chk("halted", halted, m_mode == M_HALT);
        chk("fault", fault, m_mode == M_FAULT);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk("rst_step", step, 5'b00001);
            chk("rst_req", mem_req, 1'b0);
            chk("rst_halted", halted, 1'b0);
            chk("rst_fault", fault, 1'b0);
            chk("rst_done", instr_done, 1'b0);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;

        tbl[0]  = '{0,1,0,0,0,0,1, 5'b00001, 1,0,0,0};
        tbl[1]  = '{0,1,0,0,0,0,1, 5'b00010, 0,1,0,0};
        tbl[2]  = '{0,1,0,0,0,0,1, 5'b00100, 0,0,0,0};
        tbl[3]  = '{0,1,0,0,0,0,1, 5'b01000, 0,0,0,0};
        tbl[4]  = '{0,1,0,0,0,0,1, 5'b10000, 0,0,0,0};
        tbl[5]  = '{0,1,0,1,0,0,1, 5'b00001, 0,0,1,0};
        tbl[6]  = '{0,1,0,0,0,0,1, 5'b00001, 1,0,0,0};
        tbl[7]  = '{0,1,0,0,0,0,1, 5'b00010, 0,1,0,0};
        tbl[8]  = '{0,1,0,0,0,0,1, 5'b00100, 0,0,0,0};
        tbl[9]  = '{0,1,0,1,0,0,1, 5'b00001, 0,0,1,0};
        tbl[10] = '{0,1,0,0,0,0,1, 5'b00001, 1,0,0,0};
        tbl[11] = '{0,1,0,0,0,0,1, 5'b00010, 0,1,0,0};
        tbl[12] = '{0,1,0,1,1,0,1, 5'b00001, 0,0,1,1};

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].rst, tbl[i].rdy, tbl[i].need, tbl[i].last, tbl[i].halt, tbl[i].resume, tbl[i].ack);
            tick();
            chk($sformatf("tbl%0d_step", i), step, tbl[i].step);
            chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].req);
            chk($sformatf("tbl%0d_iren", i), last_iren, tbl[i].iren);
            chk($sformatf("tbl%0d_done", i), instr_done, tbl[i].done);
            chk($sformatf("tbl%0d_halted", i), halted, tbl[i].hlt);
        end

        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
            tick();
            if (mem_req) cnt_a++;
        end
        chk("halt_req_cycles", cnt_a, 0);
        chk("halt_held", halted, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("resume_halted", halted, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("resume_fetch_req", mem_req, 1'b1);

        do_reset();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, logic'(i == 4));
            tick();
            if (mem_req) cnt_a++;
            if (last_iren) cnt_b++;
            if (i < 4) chk("delay_step_hold", step, 5'b00001);
        end
        chk("delay_req_cycles", cnt_a, 4);
        chk("delay_iren_pulses", cnt_b, 1);
        chk("delay_step_after", step, 5'b00010);

        do_reset();
        cnt_a = 0;
        for (int i = 0; i < 30 && !fault; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (mem_req) cnt_a++;
        end
        chk("timeout_req_cycles", cnt_a, LIMIT);
        chk("timeout_fault", fault, 1'b1);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk("fault_sticky", fault, 1'b1);
            chk("fault_no_req", mem_req, 1'b0);
        end

        do_reset();
        for (int i = 0; i < LIMIT; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("late_ack_no_fault", fault, 1'b0);
        chk("late_ack_step", step, 5'b00010);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            chk("rdy_freeze_step", step, 5'b00100);
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("unmasked_need_step", step, 5'b01000);
        tick();
        chk("masked_need_req", mem_req, 1'b1);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_in_wait_req", mem_req, 1'b0);
        chk("rst_in_wait_step", step, 5'b00001);

        for (int i = 0; i < 2000; i++) begin
            set_in(logic'($urandom_range(0, 63) == 0), logic'($urandom_range(0, 3) != 0),
                   1'($urandom), logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                   logic'($urandom_range(0, 7) == 0), 1'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
